// File: rtl/shifter_pipe_if.sv
// Operand/result bundle for shifter_pipe: flush, the request side (in_*) and the result side (out_*).
// The design's ports use the slave modport; a producer/consumer pair drives it through master.
interface shifter_pipe_if #(
    parameter int WIDTH = 16
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_cnt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output flush, in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  flush, in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shifter_pipe.sv
// Pipelined rotate/shift unit: log2(WIDTH) barrel levels, one register stage per REG_EVERY levels.
// Latency: result visible STAGES-1 edges after the accepting edge; 1 op/cycle when out_ready stays high.
// Backpressure: per-stage valid/ready, bubbles collapse; out_ready reaches in_ready combinationally. SHIFTER_PIPE_SRA_EN makes op 11 arithmetic.
module shifter_pipe #(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    shifter_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int CNT_W  = LEVELS;
    localparam int STAGES = (LEVELS + REG_EVERY - 1) / REG_EVERY;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [CNT_W-1:0] cnt;
        op_e              op;
`ifdef SHIFTER_PIPE_SRA_EN
        logic             sign;
`endif
    } stage_t;

    // One barrel level: shift/rotate by sh (a power of two, 1..WIDTH/2).
    function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] d,
                                                   input op_e              op,
                                                   input logic             fill,
                                                   input int               sh);
        logic [WIDTH-1:0] r;
        case (op)
            OP_ROL:  r = (d << sh) | (d >> (WIDTH - sh));
            OP_SLL:  r = d << sh;
            OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
            default: r = (d >> sh) | (fill ? ~({WIDTH{1'b1}} >> sh) : '0);
        endcase
        return r;
    endfunction

    stage_t            stage_q [STAGES];
    stage_t            stage_d [STAGES];
    stage_t            src     [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] adv;
    logic              in_rdy;

    always_comb begin
        adv[STAGES-1] = !vld_q[STAGES-1] || bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = !vld_q[k] || adv[k+1];
        end
    end

    assign in_rdy = adv[0] && !bus.flush;

    always_comb begin
        src[0].dat = bus.in_data;
        src[0].cnt = bus.in_cnt;
        src[0].op  = op_e'(bus.in_op);
`ifdef SHIFTER_PIPE_SRA_EN
        src[0].sign = bus.in_data[WIDTH-1];
`endif
        src_vld[0] = bus.in_valid && in_rdy;
        for (int k = 1; k < STAGES; k++) begin
            src[k]     = stage_q[k-1];
            src_vld[k] = vld_q[k-1];
        end
    end

    always_comb begin
        stage_t cur;
        logic   fill;
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k] = stage_q[k];
            vld_d[k]   = vld_q[k];
            cur        = src[k];
`ifdef SHIFTER_PIPE_SRA_EN
            fill = cur.sign;
`else
            fill = 1'b0;
`endif
            // Stage k owns levels k*REG_EVERY .. (k+1)*REG_EVERY-1; the cnt travels whole.
            for (int l = 0; l < LEVELS; l++) begin
                if ((l / REG_EVERY) == k && cur.cnt[l]) begin
                    cur.dat = shift_lvl(cur.dat, cur.op, fill, 1 << l);
                end
            end
            if (bus.flush) begin
                vld_d[k] = 1'b0;
            end else if (adv[k]) begin
                vld_d[k]   = src_vld[k];
                stage_d[k] = cur;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            stage_q <= '{default: '0};
        end else begin
            vld_q   <= vld_d;
            stage_q <= stage_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.out_data  = stage_q[STAGES-1].dat;

    // Only the data of the last stage leaves the block.
    logic unused_tail;
    assign unused_tail = ^stage_q[STAGES-1];
endmodule
